// File: rtl/slip_pkg.sv
// ============================================================================
// Module   : slip_pkg
// Brief    : SLIP (RFC 1055) byte constants and decoder state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package slip_pkg;

    localparam logic [7:0] SLIP_END     = 8'hC0;
    localparam logic [7:0] SLIP_ESC     = 8'hDB;
    localparam logic [7:0] SLIP_ESC_END = 8'hDC;
    localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        ESCAPE  = 2'd2,
        DISCARD = 2'd3
    } slip_dec_state_t;

endpackage

`default_nettype wire

// File: rtl/slip_frame_decoder.sv
// ============================================================================
// Module   : slip_frame_decoder
// Brief    : SLIP frame decoder, byte AXI-Stream in, framed payload out.
//            Optional SLIP_FRAME_DECODER_STATS_EN adds frames_ok/frames_err.
// Revision : 1.0
// ============================================================================
`default_nettype none

module slip_frame_decoder
    import slip_pkg::*;
#(
    parameter  int MAX_FRAME_LEN = 256,
    localparam int LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        frame_error
`ifdef SLIP_FRAME_DECODER_STATS_EN
    ,
    output logic [31:0] frames_ok,
    output logic [31:0] frames_err
`endif
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

    slip_dec_state_t  state_q, state_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [7:0] m_tdata_q;
    logic       m_tvalid_q, m_tlast_q, m_tuser_q, frame_error_q;

    logic       s_accept;
    logic       data_vld, close, err;
    logic [7:0] data_byte;
    logic       emit, emit_last, emit_user;

    assign s_tready = !m_tvalid_q || m_tready;
    assign s_accept = s_tvalid && s_tready;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        len_d      = len_q;
        data_vld   = 1'b0;
        data_byte  = s_tdata;
        close      = 1'b0;
        err        = 1'b0;
        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_user  = 1'b0;

        if (s_accept) begin
            case (state_q)
                IDLE, ACTIVE: begin
                    if (s_tdata == SLIP_END) begin
                        close = 1'b1;
                    end else if (s_tdata == SLIP_ESC) begin
                        state_d = ESCAPE;
                    end else begin
                        data_vld = 1'b1;
                    end
                end
                ESCAPE: begin
                    if (s_tdata == SLIP_ESC_END) begin
                        data_vld  = 1'b1;
                        data_byte = SLIP_END;
                    end else if (s_tdata == SLIP_ESC_ESC) begin
                        data_vld  = 1'b1;
                        data_byte = SLIP_ESC;
                    end else begin
                        err = 1'b1;
                    end
                end
                DISCARD: begin
                    if (s_tdata == SLIP_END) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A byte that would overflow the frame turns into an abort
        if (data_vld && (len_q == MAX_LEN)) begin
            err = 1'b1;
        end

        if (err) begin
            emit       = pend_vld_q;
            emit_last  = 1'b1;
            emit_user  = 1'b1;
            pend_vld_d = 1'b0;
            len_d      = '0;
            state_d    = (s_tdata == SLIP_END) ? IDLE : DISCARD;
        end else if (data_vld) begin
            emit       = pend_vld_q;
            pend_d     = data_byte;
            pend_vld_d = 1'b1;
            len_d      = len_q + LEN_W'(1);
            state_d    = ACTIVE;
        end else if (close) begin
            emit       = pend_vld_q;
            emit_last  = 1'b1;
            pend_vld_d = 1'b0;
            len_d      = '0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            pend_q        <= '0;
            pend_vld_q    <= 1'b0;
            len_q         <= '0;
            m_tdata_q     <= '0;
            m_tvalid_q    <= 1'b0;
            m_tlast_q     <= 1'b0;
            m_tuser_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            pend_vld_q    <= pend_vld_d;
            len_q         <= len_d;
            frame_error_q <= err;
            // emit implies s_accept, so the output slot is free or draining now
            if (emit) begin
                m_tdata_q  <= pend_q;
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= emit_last;
                m_tuser_q  <= emit_user;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign m_tdata     = m_tdata_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tlast     = m_tlast_q;
    assign m_tuser     = m_tuser_q;
    assign frame_error = frame_error_q;

`ifdef SLIP_FRAME_DECODER_STATS_EN
    logic [31:0] frames_ok_q, frames_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_ok_q  <= '0;
            frames_err_q <= '0;
        end else begin
            if (emit && emit_last && !emit_user && (frames_ok_q != '1)) begin
                frames_ok_q <= frames_ok_q + 32'd1;
            end
            if (err && (frames_err_q != '1)) begin
                frames_err_q <= frames_err_q + 32'd1;
            end
        end
    end

    assign frames_ok  = frames_ok_q;
    assign frames_err = frames_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slip_frame_decoder.sv
// ============================================================================
// Module   : tb_slip_frame_decoder
// Brief    : Self-checking bench: directed vector table, reset and random
//            frames checked against a frame-level SLIP reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_slip_frame_decoder;
    import slip_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] s_tdata, m_tdata;
    logic       s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, m_tuser, frame_error;
    logic [7:0] b_s_tdata, b_m_tdata;
    logic       b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tready, b_m_tlast, b_m_tuser, b_frame_error;

`ifdef SLIP_FRAME_DECODER_STATS_EN
    logic [31:0] a_ok, a_err, b_ok, b_err;
`endif

    slip_frame_decoder #(.MAX_FRAME_LEN(256)) u_dut_a (
`ifdef SLIP_FRAME_DECODER_STATS_EN
        .frames_ok(a_ok), .frames_err(a_err),
`endif
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_error(frame_error)
    );

    slip_frame_decoder #(.MAX_FRAME_LEN(4)) u_dut_b (
`ifdef SLIP_FRAME_DECODER_STATS_EN
        .frames_ok(b_ok), .frames_err(b_err),
`endif
        .clk(clk), .reset(reset),
        .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
        .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
        .m_tlast(b_m_tlast), .m_tuser(b_m_tuser), .frame_error(b_frame_error)
    );

    assign b_m_tready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_en  = 1'b0;

    logic [9:0] got_a[$];
    logic [9:0] got_b[$];
    int         err_a = 0;
    int         err_b = 0;
    logic [9:0] exp_q[$];
    int         exp_err = 0;

    typedef struct packed {
        bit          use_b;
        int          n_in;
        logic [63:0] in_bytes;
        int          n_out;
        logic [39:0] out_beats;
        int          n_err;
    } vec_t;

    function automatic logic [9:0] mkb(input logic [7:0] d, input bit l, input bit u);
        return {u, l, d};
    endfunction

    function automatic vec_t mkv(input bit b, input int ni, input logic [63:0] ib,
                                 input int no, input logic [39:0] ob, input int ne);
        vec_t v;
        v.use_b = b; v.n_in = ni; v.in_bytes = ib;
        v.n_out = no; v.out_beats = ob; v.n_err = ne;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference: split at END, decode each frame, abort on the first fault
    function automatic void model(input logic [7:0] raw[$], input int maxlen);
        logic [7:0] seg[$];
        logic [7:0] dec[$];
        logic [7:0] v;
        bit         bad;
        int         i;
        foreach (raw[r]) begin
            if (raw[r] != SLIP_END) begin
                seg.push_back(raw[r]);
            end else begin
                dec.delete();
                bad = 1'b0;
                i   = 0;
                while (i < seg.size() && !bad) begin
                    v = seg[i];
                    if (seg[i] == SLIP_ESC) begin
                        if (i + 1 >= seg.size())            bad = 1'b1;
                        else if (seg[i+1] == SLIP_ESC_END) v = SLIP_END;
                        else if (seg[i+1] == SLIP_ESC_ESC) v = SLIP_ESC;
                        else                                bad = 1'b1;
                        i += 2;
                    end else begin
                        i += 1;
                    end
                    if (!bad) begin
                        if (dec.size() == maxlen) bad = 1'b1;
                        else                      dec.push_back(v);
                    end
                end
                for (int k = 0; k < dec.size(); k++)
                    exp_q.push_back({bad && (k == dec.size() - 1), k == dec.size() - 1, dec[k]});
                if (bad) exp_err++;
                seg.delete();
            end
        end
    endfunction

    initial begin
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            m_tready = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Output monitor plus stall-protocol checks on the main instance
    logic [9:0] stall_v;
    bit         stall_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (m_tvalid && m_tready)   got_a.push_back({m_tuser, m_tlast, m_tdata});
                if (frame_error)            err_a++;
                if (b_m_tvalid && b_m_tready) got_b.push_back({b_m_tuser, b_m_tlast, b_m_tdata});
                if (b_frame_error)          err_b++;
                if (m_tvalid && !m_tready) begin
                    n_tests++;
                    if (s_tready) begin
                        n_fail++;
                        $display("FAIL s_tready_in_stall: s_tready=%b required 0", s_tready);
                    end
                end
                if (stall_prev) begin
                    n_tests++;
                    if (!m_tvalid || ({m_tuser, m_tlast, m_tdata} != stall_v)) begin
                        n_fail++;
                        $display("FAIL stall_stable: got v=%b %03h expected v=1 %03h",
                                 m_tvalid, {m_tuser, m_tlast, m_tdata}, stall_v);
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                stall_v    = {m_tuser, m_tlast, m_tdata};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic send_byte(input bit sel_b, input logic [7:0] b);
        int waited;
        bit done;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (sel_b) begin b_s_tdata = b; b_s_tvalid = 1'b1; end
            else       begin s_tdata = b;   s_tvalid = 1'b1;   end
            #1;
            if (sel_b ? b_s_tready : s_tready) begin
                done = 1'b1;
            end else begin
                waited = waited + 1;
                if (waited > 200) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: byte %02h not accepted, required accept", b);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_tvalid   = 1'b0;
        b_s_tvalid = 1'b0;
    endtask

    task automatic drain();
        rnd_en = 1'b0;
        repeat (10) @(negedge clk);
        #3;
    endtask

    task automatic clear_all();
        got_a.delete(); got_b.delete(); exp_q.delete();
        err_a = 0; err_b = 0; exp_err = 0;
    endtask

    task automatic run_random(input bit sel_b, input int nframes);
        logic [7:0] raw[$];
        logic [7:0] d;
        logic [9:0] gq[$];
        int         plen, mode, pos;
        clear_all();
        for (int f = 0; f < nframes; f++) begin
            if ($urandom_range(0, 7) == 0) raw.push_back(SLIP_END);
            plen = sel_b ? $urandom_range(0, 7) : 64;
            mode = $urandom_range(0, 9);
            pos  = $urandom_range(0, plen);
            for (int j = 0; j < plen; j++) begin
                if (j == pos && mode == 0) begin raw.push_back(SLIP_ESC); raw.push_back(8'h37); end
                if (j == pos && mode == 1) begin raw.push_back(SLIP_ESC); break; end
                d = 8'($urandom);
                if (j % 9 == 3) d = ($urandom_range(0, 1) != 0) ? SLIP_END : SLIP_ESC;
                if (d == SLIP_END)      begin raw.push_back(SLIP_ESC); raw.push_back(SLIP_ESC_END); end
                else if (d == SLIP_ESC) begin raw.push_back(SLIP_ESC); raw.push_back(SLIP_ESC_ESC); end
                else                    raw.push_back(d);
            end
            raw.push_back(SLIP_END);
        end
        model(raw, sel_b ? 4 : 256);
        rnd_en = !sel_b;
        foreach (raw[k]) begin
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            send_byte(sel_b, raw[k]);
        end
        drain();
        if (sel_b) gq = got_b; else gq = got_a;
        chk(sel_b ? "rnd_b_count" : "rnd_a_count", gq.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < gq.size(); k++)
            chk($sformatf("%s_beat%0d", sel_b ? "rnd_b" : "rnd_a", k), gq[k], exp_q[k]);
        chk(sel_b ? "rnd_b_errors" : "rnd_a_errors", sel_b ? err_b : err_a, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    vec_t       vecs[10];
    logic [9:0] gq[$];

    initial begin
        reset = 1'b0;
        s_tdata = '0;   s_tvalid = 1'b0;
        b_s_tdata = '0; b_s_tvalid = 1'b0;

        vecs[0] = mkv(0, 5, {8'hC0, 8'h01, 8'h02, 8'h03, 8'hC0, 24'h0},
                      3, {mkb(8'h01,0,0), mkb(8'h02,0,0), mkb(8'h03,1,0), 10'h0}, 0);
        vecs[1] = mkv(0, 6, {8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0, 16'h0},
                      2, {mkb(8'hC0,0,0), mkb(8'hDB,1,0), 20'h0}, 0);
        vecs[2] = mkv(0, 3, {8'hC0, 8'hC0, 8'hC0, 40'h0}, 0, 40'h0, 0);
        vecs[3] = mkv(0, 6, {8'h11, 8'hDB, 8'h05, 8'h22, 8'h33, 8'hC0, 16'h0},
                      1, {mkb(8'h11,1,1), 30'h0}, 1);
        vecs[4] = mkv(0, 2, {8'h44, 8'hC0, 48'h0}, 1, {mkb(8'h44,1,0), 30'h0}, 0);
        vecs[5] = mkv(1, 5, {8'h01, 8'h02, 8'h03, 8'h04, 8'hC0, 24'h0},
                      4, {mkb(8'h01,0,0), mkb(8'h02,0,0), mkb(8'h03,0,0), mkb(8'h04,1,0)}, 0);
        vecs[6] = mkv(1, 6, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hC0, 16'h0},
                      4, {mkb(8'h01,0,0), mkb(8'h02,0,0), mkb(8'h03,0,0), mkb(8'h04,1,1)}, 1);
        vecs[7] = mkv(0, 3, {8'h55, 8'hDB, 8'hC0, 40'h0}, 1, {mkb(8'h55,1,1), 30'h0}, 1);
        vecs[8] = mkv(0, 2, {8'h66, 8'hC0, 48'h0}, 1, {mkb(8'h66,1,0), 30'h0}, 0);
        vecs[9] = mkv(1, 4, {8'hDB, 8'hDB, 8'h07, 8'hC0, 32'h0}, 0, 40'h0, 1);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_s_tready", s_tready, 1);
        chk("rst_b_m_tvalid", b_m_tvalid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            clear_all();
            for (int k = 0; k < vecs[i].n_in; k++)
                send_byte(vecs[i].use_b, vecs[i].in_bytes[63 - 8*k -: 8]);
            drain();
            if (vecs[i].use_b) gq = got_b; else gq = got_a;
            chk($sformatf("vec%0d_count", i), gq.size(), vecs[i].n_out);
            for (int k = 0; k < vecs[i].n_out && k < gq.size(); k++)
                chk($sformatf("vec%0d_beat%0d", i, k), gq[k], vecs[i].out_beats[39 - 10*k -: 10]);
            chk($sformatf("vec%0d_errors", i), vecs[i].use_b ? err_b : err_a, vecs[i].n_err);
        end

        // Reset in the middle of an open frame
        clear_all();
        send_byte(0, 8'h01);
        send_byte(0, 8'h02);
        chk("midrst_pre_tvalid", m_tvalid, 1);
        chk("midrst_pre_tdata", m_tdata, 8'h01);
        reset = 1'b0;
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_m_tdata", m_tdata, 0);
        chk("midrst_m_tlast", m_tlast, 0);
        chk("midrst_m_tuser", m_tuser, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_all();
        send_byte(0, 8'h05);
        send_byte(0, SLIP_END);
        drain();
        chk("postrst_count", got_a.size(), 1);
        if (got_a.size() > 0) chk("postrst_beat", got_a[0], mkb(8'h05, 1, 0));
        chk("postrst_errors", err_a, 0);

        run_random(0, 20);
        run_random(1, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/slip_frame_decoder.md
Name: slip_frame_decoder

Overview:
- Sits directly downstream of the UART receiver and consumes its byte-per-beat AXI-Stream.
- Decodes SLIP framing (RFC 1055): END=0xC0, ESC=0xDB, ESC_END=0xDC, ESC_ESC=0xDD.
- Emits decoded payload bytes as packets, with tlast on the final byte of each frame and tuser flagging aborted frames.
- Feeds the command/packet layer above the UART.

Parameters:
MAX_FRAME_LEN, 256, maximum decoded payload bytes per frame; longer frames are aborted.
LEN_W, $clog2(MAX_FRAME_LEN+1), width of the frame-length counter (derived, not overridden).

Ports:
clk  in  1  single clock domain.
reset  in  1  asynchronous, active-low reset.
s_tdata  in  8  raw byte from the UART RX stream.
s_tvalid  in  1  input byte valid.
s_tready  out  1  input ready.
m_tdata  out  8  decoded payload byte.
m_tvalid  out  1  output valid.
m_tready  in  1  downstream ready.
m_tlast  out  1  last byte of a frame.
m_tuser  out  1  frame aborted (valid only with m_tlast=1).
frame_error  out  1  one-cycle pulse on each protocol or length error.

Behaviour:
- Reset (async assert when reset=0, sync release) sets outputs and state:
  - m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, frame_error=0.
  - state=IDLE, pending_valid=0, length=0.
- Output register: m_* are registered.
  - s_tready = !m_tvalid || m_tready, combinational.
  - A beat is accepted when s_tvalid && s_tready.
  - m_tvalid clears on m_tready with no new emission in the same cycle.
- Pending byte: the decoder holds one decoded byte, because tlast is only known when the next byte or END arrives.
  - A decoded data byte is presented on m_* 1 cycle after the following data byte or END is accepted.
- States:
  - IDLE: no frame open.
  - ACTIVE: frame open.
  - ESCAPE: ESC seen.
  - DISCARD: drop bytes until END.
- Data byte accepted in IDLE/ACTIVE (non-END, non-ESC) or a valid escape completion in ESCAPE:
  - If pending_valid, emit pending with tlast=0, tuser=0.
  - The new byte becomes pending; length++; state=ACTIVE.
- ESC in IDLE/ACTIVE: state=ESCAPE; nothing emitted.
- In ESCAPE:
  - 0xDC decodes to 0xC0.
  - 0xDD decodes to 0xDB.
  - Any other non-END byte is an error.
  - END is an error, and the frame closes.
- END in ACTIVE: emit pending with tlast=1, tuser=0; length=0; state=IDLE.
- END in IDLE (no pending): empty frame; silently dropped, no emission.
- Error (bad escape, END in ESCAPE, or a data byte that would make length exceed MAX_FRAME_LEN):
  - frame_error pulses.
  - If pending_valid, emit pending with tlast=1, tuser=1.
  - pending_valid=0; length=0.
  - Next state is IDLE if the error byte was END, otherwise DISCARD.
- DISCARD: all bytes accepted and dropped; END goes to IDLE with no emission.
- A frame of exactly MAX_FRAME_LEN bytes is legal.
- Simultaneous m_tready and a new emission: the output register reloads in the same cycle with no bubble.
- Reset mid-frame: all in-flight data is discarded, including pending and output register contents; no tlast is generated.

Optional Feature:
SLIP_FRAME_DECODER_STATS_EN:
- When defined, adds outputs frames_ok (32-bit) and frames_err (32-bit), both cleared by reset.
  - frames_ok increments on each tlast=1, tuser=0 emission.
  - frames_err increments on each frame_error pulse.
  - Both saturate at all-ones.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package slip_pkg holds:
  - SLIP_END, SLIP_ESC, SLIP_ESC_END, SLIP_ESC_ESC byte constants.
  - The slip_dec_state_t enum (IDLE, ACTIVE, ESCAPE, DISCARD).
- No sub-module. The output register is inline; it is too small to justify a separate skid-buffer module.

Test Plan:
- C0 01 02 03 C0 with m_tready=1 -> 01(tlast0), 02(tlast0), 03(tlast1,tuser0); frame_error never pulses.
- C0 DB DC DB DD C0 -> C0(tlast0), DB(tlast1); C0 C0 C0 -> no output beats.
- 11 DB 05 22 33 C0 -> 11(tlast1,tuser1), one frame_error pulse, 22/33 dropped; a following 44 C0 yields 44(tlast1,tuser0).
- MAX_FRAME_LEN=4: 01 02 03 04 C0 -> four bytes, last tlast1 tuser0. 01 02 03 04 05 C0 -> 01 02 03 04(tlast1,tuser1), frame_error pulse on the 05 byte.
- Back-to-back 64-byte frames with m_tready randomly toggled:
  - s_tready never high while m_tvalid && !m_tready.
  - m_* stable while stalled.
  - Byte order and count preserved.
- reset=0 asserted mid-frame after 01 02 -> outputs zero immediately; after release, 05 C0 yields only 05(tlast1).
